// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, SPI mode encodings and counter sizing helper
package spi_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    // {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Width of a counter running 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: synchronous FIFO with registered full/empty flags
module spi_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr, r_rptr;
    logic [AW:0]       w_wptr_nxt, w_rptr_nxt;
    logic              r_full, r_empty;

    assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, i_wr};
    assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, i_rd};

    // Storage array, written on every accepted word
    always_ff @(posedge i_clk)
        if (i_wr)
            r_mem[r_wptr[AW-1:0]] <= i_wdata;

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_full  <= w_wptr_nxt == {~w_rptr_nxt[AW], w_rptr_nxt[AW-1:0]};
            r_empty <= w_wptr_nxt == w_rptr_nxt;
        end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/spi_stream_tx.sv
// spi_stream_tx: buffered SPI master transmitter with configurable mode, width, divider and gap
module spi_stream_tx
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int CLK_DIV    = 2,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              myreset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mosi,
    output logic              sck,
    output logic              busy,
    output logic              done
);
    localparam int              HW     = cnt_w(CLK_DIV);
    localparam int              BW     = $clog2(DATA_W);
    localparam int              GW     = cnt_w(GAP_CYCLES);
    localparam logic [HW-1:0]   H_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0]   B_LAST = BW'(DATA_W - 1);
    localparam logic [GW-1:0]   G_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [1:0]      MODE   = {CPOL, CPHA};
    // sck level during phase A; phase B is its inverse
    localparam logic            A_LVL  = (MODE == MODE1) || (MODE == MODE2);

    state_t            r_state, w_state_nxt;
    logic [HW-1:0]     r_half, w_half_nxt;
    logic              r_phase, w_phase_nxt;
    logic [BW-1:0]     r_bit, w_bit_nxt;
    logic [GW-1:0]     r_gap, w_gap_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt, w_shifted;
    logic              r_mosi, w_mosi_nxt;
    logic              r_sck, w_sck_nxt;
    logic              r_done, r_busy;
    logic              w_wr, w_rd, w_full, w_empty;
    logic [DATA_W-1:0] w_rdata;

    function automatic logic first_bit(input logic [DATA_W-1:0] d);
        return MSB_FIRST ? d[DATA_W-1] : d[0];
    endfunction

    assign w_wr      = in_valid && !w_full;
    assign w_shifted = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

    spi_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (myreset),
        .i_wr    (w_wr),
        .i_wdata (in_data),
        .i_rd    (w_rd),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-state, counters and shift data; each bit is phase A then phase B of CLK_DIV cycles
    always_comb begin
        w_state_nxt = r_state;
        w_half_nxt  = r_half;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_gap_nxt   = r_gap;
        w_shift_nxt = r_shift;
        w_mosi_nxt  = r_mosi;
        w_rd        = 1'b0;
        case (r_state)
            IDLE: begin
                w_mosi_nxt = 1'b0;
                if (!w_empty)
                    w_state_nxt = LOAD;
            end
            LOAD: begin
                w_rd        = 1'b1;
                w_shift_nxt = w_rdata;
                w_mosi_nxt  = first_bit(w_rdata);
                w_half_nxt  = '0;
                w_phase_nxt = 1'b0;
                w_bit_nxt   = '0;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (r_half != H_LAST) begin
                    w_half_nxt = r_half + 1'b1;
                end else begin
                    w_half_nxt  = '0;
                    w_phase_nxt = !r_phase;
                    if (r_phase && r_bit == B_LAST) begin
                        w_state_nxt = GAP;
                        w_gap_nxt   = '0;
                        w_mosi_nxt  = 1'b0;
                    end else if (r_phase) begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = w_shifted;
                        w_mosi_nxt  = first_bit(w_shifted);
                    end
                end
            end
            default: begin
                w_mosi_nxt = 1'b0;
                if (r_gap != G_LAST)
                    w_gap_nxt = r_gap + 1'b1;
                else
                    w_state_nxt = w_empty ? IDLE : LOAD;
            end
        endcase
        w_sck_nxt = (w_state_nxt == SHIFT) ? (w_phase_nxt ? !A_LVL : A_LVL) : CPOL;
    end

    // State and registered outputs; reset drops sck to its idle level immediately
    always_ff @(posedge CLK or negedge myreset)
        if (!myreset) begin
            r_state <= IDLE;
            r_half  <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_shift <= '0;
            r_mosi  <= 1'b0;
            r_sck   <= CPOL;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_half  <= w_half_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            r_gap   <= w_gap_nxt;
            r_shift <= w_shift_nxt;
            r_mosi  <= w_mosi_nxt;
            r_sck   <= w_sck_nxt;
            r_done  <= (w_state_nxt == GAP) && (r_state != GAP);
            r_busy  <= (w_state_nxt != IDLE) || w_wr || !w_empty;
        end

    assign in_ready = !w_full;
    assign mosi     = r_mosi;
    assign sck      = r_sck;
    assign done     = r_done;
    assign busy     = r_busy;

endmodule
